// File: rtl/riscv_defines.sv
// Shared RISC-V core constants: FPU command encodings, rounding-mode and flag widths.
package riscv_defines;

  localparam int C_CMD   = 4;
  localparam int C_RM    = 3;
  localparam int C_FFLAG = 5;

  localparam logic [C_CMD-1:0] C_FPU_ADD_CMD    = 4'h0;
  localparam logic [C_CMD-1:0] C_FPU_SUB_CMD    = 4'h1;
  localparam logic [C_CMD-1:0] C_FPU_MUL_CMD    = 4'h2;
  localparam logic [C_CMD-1:0] C_FPU_DIV_CMD    = 4'h3;
  localparam logic [C_CMD-1:0] C_FPU_I2F_CMD    = 4'h4;
  localparam logic [C_CMD-1:0] C_FPU_F2I_CMD    = 4'h5;
  localparam logic [C_CMD-1:0] C_FPU_SQRT_CMD   = 4'h6;
  localparam logic [C_CMD-1:0] C_FPU_NOP_CMD    = 4'h7;
  localparam logic [C_CMD-1:0] C_FPU_FMADD_CMD  = 4'h8;
  localparam logic [C_CMD-1:0] C_FPU_FMSUB_CMD  = 4'h9;
  localparam logic [C_CMD-1:0] C_FPU_FNMADD_CMD = 4'hA;
  localparam logic [C_CMD-1:0] C_FPU_FNMSUB_CMD = 4'hB;

endpackage

// File: rtl/riscv_fpu_tag_fifo.sv
// Synchronous FIFO of owner tags for a shared in-order execution unit.
// Push is ignored when full and pop is ignored when empty.
module riscv_fpu_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // next-state for pointers (explicit wrap keeps DEPTH=1 correct) and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // pointer and occupancy registers, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // tag storage; contents are don't-care while empty, so no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/riscv_fpu_share_arb.sv
// Round-robin sharing of one in-order FPU between NB_CORES cores. Issue is
// combinational; each result is routed to its owner one cycle after return.
module riscv_fpu_share_arb
  import riscv_defines::*;
#(
  parameter int NB_CORES        = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ID_W            = $clog2(NB_CORES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               core_req_i    [NB_CORES],
  output logic               core_gnt_o    [NB_CORES],
  input  logic [31:0]        core_op_a_i   [NB_CORES],
  input  logic [31:0]        core_op_b_i   [NB_CORES],
  input  logic [31:0]        core_op_c_i   [NB_CORES],
  input  logic [C_CMD-1:0]   core_cmd_i    [NB_CORES],
  input  logic [C_RM-1:0]    core_rm_i     [NB_CORES],
  output logic               core_rvalid_o [NB_CORES],
  output logic [31:0]        core_result_o,
  output logic [C_FFLAG-1:0] core_flags_o,
  output logic               fpu_req_o,
  input  logic               fpu_gnt_i,
  output logic [31:0]        fpu_op_a_o,
  output logic [31:0]        fpu_op_b_o,
  output logic [31:0]        fpu_op_c_o,
  output logic [C_CMD-1:0]   fpu_cmd_o,
  output logic [C_RM-1:0]    fpu_rm_o,
  input  logic               fpu_rvalid_i,
  input  logic [31:0]        fpu_result_i,
  input  logic [C_FFLAG-1:0] fpu_flags_i,
  output logic               err_o
);

  logic [ID_W-1:0]     rr_q, rr_d;
  logic [ID_W-1:0]     winner;
  logic [ID_W-1:0]     scan_idx;
  logic                found;
  logic                any_req;
  logic                handshake;
  logic                fifo_full, fifo_empty;
  logic [ID_W-1:0]     head_tag;
  logic                pop, spurious;
  logic [NB_CORES-1:0] rvalid_q, rvalid_d;
  logic [31:0]         result_q;
  logic [C_FFLAG-1:0]  flags_q;
  logic                err_q;

  // round-robin pick: first requester at or above rr_q, wrapping
  always_comb begin
    winner   = rr_q;
    scan_idx = '0;
    found    = 1'b0;
    any_req  = 1'b0;
    for (int i = 0; i < NB_CORES; i++) begin
      scan_idx = ID_W'((int'(rr_q) + i) % NB_CORES);
      if (!found && core_req_i[scan_idx]) begin
        winner = scan_idx;
        found  = 1'b1;
      end
      any_req = any_req | core_req_i[i];
    end
  end

  // operands follow the winner even when the FIFO blocks issue
  assign fpu_op_a_o = core_op_a_i[winner];
  assign fpu_op_b_o = core_op_b_i[winner];
  assign fpu_op_c_o = core_op_c_i[winner];
  assign fpu_cmd_o  = core_cmd_i[winner];
  assign fpu_rm_o   = core_rm_i[winner];

  // no pop-to-push bypass: a full FIFO blocks issue even if a result returns now
  assign fpu_req_o = rst_n & any_req & ~fifo_full;
  assign handshake = fpu_req_o & fpu_gnt_i;
  assign pop       = fpu_rvalid_i & ~fifo_empty;
  assign spurious  = fpu_rvalid_i & fifo_empty;

  // grant fan-out, pointer advance and return demux
  always_comb begin
    rr_d = rr_q;
    if (handshake) rr_d = (winner == ID_W'(NB_CORES - 1)) ? '0 : winner + 1'b1;
    for (int i = 0; i < NB_CORES; i++) begin
      core_gnt_o[i]    = handshake & (winner == ID_W'(i));
      rvalid_d[i]      = pop & (head_tag == ID_W'(i));
      core_rvalid_o[i] = rvalid_q[i];
    end
  end

  riscv_fpu_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (ID_W)
  ) u_tag_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (handshake),
    .push_data_i (winner),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head_tag)
  );

  // registered return path, round-robin pointer and sticky error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q     <= '0;
      rvalid_q <= '0;
      result_q <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_q     <= rr_d;
      rvalid_q <= rvalid_d;
      if (pop) begin
        result_q <= fpu_result_i;
        flags_q  <= fpu_flags_i;
      end
      if (spurious) err_q <= 1'b1;
    end
  end

  assign core_result_o = result_q;
  assign core_flags_o  = flags_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_riscv_fpu_share_arb.sv
// Scoreboard bench for riscv_fpu_share_arb: stimulus pushes expected grants
// and returns into queues, a negedge monitor pops and compares.
module tb_riscv_fpu_share_arb;
  import riscv_defines::*;

  localparam int N = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               core_req    [N];
  logic               core_gnt    [N];
  logic [31:0]        op_a        [N];
  logic [31:0]        op_b        [N];
  logic [31:0]        op_c        [N];
  logic [C_CMD-1:0]   cmd         [N];
  logic [C_RM-1:0]    rm          [N];
  logic               core_rvalid [N];
  logic [31:0]        core_result;
  logic [C_FFLAG-1:0] core_flags;
  logic               fpu_req, fpu_gnt;
  logic [31:0]        fpu_op_a, fpu_op_b, fpu_op_c;
  logic [C_CMD-1:0]   fpu_cmd;
  logic [C_RM-1:0]    fpu_rm;
  logic               fpu_rvalid;
  logic [31:0]        fpu_result;
  logic [C_FFLAG-1:0] fpu_flags;
  logic               err;

  typedef struct {
    int                 core;
    logic [31:0]        res;
    logic [C_FFLAG-1:0] fl;
  } ret_t;

  int   checks = 0;
  int   errors = 0;
  int   exp_gnt[$];
  ret_t exp_ret[$];

  riscv_fpu_share_arb #(.NB_CORES(N), .MAX_OUTSTANDING(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .core_req_i    (core_req),
    .core_gnt_o    (core_gnt),
    .core_op_a_i   (op_a),
    .core_op_b_i   (op_b),
    .core_op_c_i   (op_c),
    .core_cmd_i    (cmd),
    .core_rm_i     (rm),
    .core_rvalid_o (core_rvalid),
    .core_result_o (core_result),
    .core_flags_o  (core_flags),
    .fpu_req_o     (fpu_req),
    .fpu_gnt_i     (fpu_gnt),
    .fpu_op_a_o    (fpu_op_a),
    .fpu_op_b_o    (fpu_op_b),
    .fpu_op_c_o    (fpu_op_c),
    .fpu_cmd_o     (fpu_cmd),
    .fpu_rm_o      (fpu_rm),
    .fpu_rvalid_i  (fpu_rvalid),
    .fpu_result_i  (fpu_result),
    .fpu_flags_i   (fpu_flags),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  // monitor: every grant and every core rvalid must match the next expectation
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (core_gnt[i]) begin
        if (exp_gnt.size() == 0) begin
          checks++; errors++;
          $display("FAIL gnt_unexpected got core %0d exp none", i);
        end else begin
          chk("gnt_core", i, exp_gnt.pop_front());
        end
      end
      if (core_rvalid[i]) begin
        if (exp_ret.size() == 0) begin
          checks++; errors++;
          $display("FAIL rvalid_unexpected got core %0d exp none", i);
        end else begin
          ret_t e;
          e = exp_ret.pop_front();
          chk("ret_core", i, e.core);
          chk("ret_result", core_result, e.res);
          chk("ret_flags", 32'(core_flags), 32'(e.fl));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req();
    for (int i = 0; i < N; i++) core_req[i] = 1'b0;
  endtask

  task automatic all_req();
    for (int i = 0; i < N; i++) core_req[i] = 1'b1;
  endtask

  task automatic ret(input int core, input logic [31:0] r, input logic [C_FFLAG-1:0] f);
    ret_t e;
    fpu_rvalid = 1'b1;
    fpu_result = r;
    fpu_flags  = f;
    e.core = core; e.res = r; e.fl = f;
    exp_ret.push_back(e);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  function automatic logic any_rvalid();
    logic a;
    a = 1'b0;
    for (int i = 0; i < N; i++) a = a | core_rvalid[i];
    return a;
  endfunction

  function automatic logic any_gnt();
    logic a;
    a = 1'b0;
    for (int i = 0; i < N; i++) a = a | core_gnt[i];
    return a;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    fpu_gnt    = 1'b1;
    fpu_rvalid = 1'b0;
    fpu_result = '0;
    fpu_flags  = '0;
    for (int i = 0; i < N; i++) begin
      core_req[i] = 1'b0;
      op_a[i] = 32'h1000_0000 + i;
      op_b[i] = 32'h2000_0000 + i;
      op_c[i] = 32'h3000_0000 + i;
      cmd[i]  = C_FPU_MUL_CMD;
      rm[i]   = C_RM'(i);
    end
    core_req[0] = 1'b1;

    // reset: combinational request/grant suppressed, registers at reset values
    cyc(); cyc();
    @(negedge clk);
    chk("rst_gnt0", 32'(core_gnt[0]), 0);
    chk("rst_fpu_req", 32'(fpu_req), 0);
    chk("rst_rvalid", 32'(any_rvalid()), 0);
    chk("rst_result", core_result, 0);
    chk("rst_flags", 32'(core_flags), 0);
    chk("rst_err", 32'(err), 0);
    cyc();
    core_req[0] = 1'b0;
    rst_n = 1'b1;

    // single request from core 2
    op_a[2] = 32'h3F80_0000; op_b[2] = 32'h4000_0000; cmd[2] = C_FPU_ADD_CMD;
    core_req[2] = 1'b1;
    exp_gnt.push_back(2);
    @(negedge clk);
    chk("t1_op_a", fpu_op_a, 32'h3F80_0000);
    chk("t1_op_b", fpu_op_b, 32'h4000_0000);
    chk("t1_cmd", 32'(fpu_cmd), 32'(C_FPU_ADD_CMD));
    chk("t1_req", 32'(fpu_req), 1);
    cyc();
    core_req[2] = 1'b0;
    ret(2, 32'h4040_0000, '0);
    cyc();
    fpu_rvalid = 1'b0;
    core_req[0] = 1'b1; core_req[3] = 1'b1;
    exp_gnt.push_back(3);
    @(negedge clk);
    chk("t1_rr_is_3", 32'(core_gnt[3]), 1);
    cyc();
    core_req[3] = 1'b0;
    exp_gnt.push_back(0);
    cyc();
    core_req[0] = 1'b0;
    ret(3, 32'h1111_1111, 5'h01);
    cyc();
    ret(0, 32'h2222_2222, 5'h02);
    cyc();
    fpu_rvalid = 1'b0;
    cyc();
    chk("t1_drain", exp_ret.size(), 0);

    // all cores streaming with one return per cycle
    reset_pulse();
    for (int k = 0; k <= 5; k++) begin
      if (k < 5) begin
        all_req();
        exp_gnt.push_back(k % N);
      end else begin
        clear_req();
      end
      if (k >= 1) ret((k - 1) % N, 32'hA000_0000 + k - 1, C_FFLAG'(k));
      if (k < 5) begin
        @(negedge clk);
        chk("t2_op_a", fpu_op_a, op_a[k % N]);
        chk("t2_rm", 32'(fpu_rm), k % N);
      end
      cyc();
    end
    fpu_rvalid = 1'b0;
    cyc();
    chk("t2_drain", exp_ret.size() + exp_gnt.size(), 0);

    // backpressure: fill the tag FIFO, a same-cycle return must not unblock issue
    for (int k = 0; k < 4; k++) begin
      all_req();
      exp_gnt.push_back((1 + k) % N);
      cyc();
    end
    @(negedge clk);
    chk("t3_full_req", 32'(fpu_req), 0);
    cyc();
    ret(1, 32'hB000_0001, 5'h03);
    @(negedge clk);
    chk("t3_pop_no_req", 32'(fpu_req), 0);
    chk("t3_pop_no_gnt", 32'(any_gnt()), 0);
    cyc();
    fpu_rvalid = 1'b0;
    exp_gnt.push_back(1);
    @(negedge clk);
    chk("t3_regrant", 32'(core_gnt[1]), 1);
    cyc();
    clear_req();

    // push and pop together at two outstanding, then refill to confirm count
    ret(2, 32'hC000_0002, 5'h04);
    cyc();
    ret(3, 32'hC000_0003, 5'h05);
    cyc();
    ret(0, 32'hC000_0000, 5'h06);
    core_req[2] = 1'b1;
    exp_gnt.push_back(2);
    cyc();
    fpu_rvalid = 1'b0;
    core_req[2] = 1'b0; core_req[3] = 1'b1; core_req[0] = 1'b1;
    exp_gnt.push_back(3);
    cyc();
    core_req[3] = 1'b0;
    exp_gnt.push_back(0);
    cyc();
    @(negedge clk);
    chk("t4_count_full", 32'(fpu_req), 0);
    cyc();
    clear_req();
    ret(1, 32'hD000_0001, 5'h07);
    cyc();
    ret(2, 32'hD000_0002, 5'h08);
    cyc();
    ret(3, 32'hD000_0003, 5'h09);
    cyc();
    ret(0, 32'hD000_0000, 5'h0A);
    cyc();
    fpu_rvalid = 1'b0;
    cyc();
    chk("t4_drain", exp_ret.size() + exp_gnt.size(), 0);

    // spurious return on empty FIFO
    fpu_rvalid = 1'b1; fpu_result = 32'hDEAD_BEEF; fpu_flags = 5'h1F;
    cyc();
    fpu_rvalid = 1'b0;
    @(negedge clk);
    chk("t5_err_set", 32'(err), 1);
    chk("t5_no_rvalid", 32'(any_rvalid()), 0);
    cyc(); cyc();
    @(negedge clk);
    chk("t5_err_sticky", 32'(err), 1);
    cyc();
    reset_pulse();
    @(negedge clk);
    chk("t5_err_clr", 32'(err), 0);
    cyc();

    // reset with three operations outstanding
    for (int k = 0; k < 4; k++) begin
      all_req();
      exp_gnt.push_back(k);
      cyc();
    end
    clear_req();
    ret(0, 32'hCAFE_F00D, 5'h1F);
    cyc();
    fpu_rvalid = 1'b0;
    rst_n = 1'b0;
    all_req();
    @(negedge clk);
    chk("t6_rst_req", 32'(fpu_req), 0);
    chk("t6_rst_gnt", 32'(any_gnt()), 0);
    cyc();
    @(negedge clk);
    chk("t6_rst_result", core_result, 0);
    chk("t6_rst_flags", 32'(core_flags), 0);
    chk("t6_rst_rvalid", 32'(any_rvalid()), 0);
    chk("t6_rst_err", 32'(err), 0);
    cyc();
    rst_n = 1'b1;
    exp_gnt.push_back(0);
    @(negedge clk);
    chk("t6_restart_gnt0", 32'(core_gnt[0]), 1);
    cyc();
    clear_req();
    ret(0, 32'h1234_5678, 5'h02);
    cyc();
    fpu_rvalid = 1'b1; fpu_result = 32'h0BAD_0BAD;
    cyc();
    fpu_rvalid = 1'b0;
    @(negedge clk);
    chk("t6_stale_return_err", 32'(err), 1);
    cyc();

    chk("end_gnt_queue", exp_gnt.size(), 0);
    chk("end_ret_queue", exp_ret.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
